// File: rtl/multi_clk_div_pkg.sv
// Shared types and defaults for the multi-channel DDS clock divider.
package multi_clk_div_pkg;

    localparam int DEF_ACC_W       = 32;
    localparam int DEF_LOCK_CYCLES = 16;
    localparam int CNT_W           = 8;
    localparam int CHAN_W          = 3;

    typedef enum logic [1:0] {
        ST_SETTLE = 2'd0,
        ST_APPLY  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

endpackage

// File: rtl/multi_clk_div_dds_channel.sv
// One phase-accumulator channel: increment, stored phase, wrap strobe and MSB clock.
module dds_channel
    import multi_clk_div_pkg::*;
#(
    parameter int               ACC_W     = DEF_ACC_W,
    parameter logic [ACC_W-1:0] INIT_INCR = '0
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             load_cfg,
    input  logic             load_sync,
    input  logic [ACC_W-1:0] cfg_incr,
    input  logic [ACC_W-1:0] cfg_phase,
    output logic             carry_out,
    output logic             msb_out
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] incr_q, incr_d;
    logic [ACC_W-1:0] phase_q, phase_d;
    logic             carry_q, carry_d;
    logic [ACC_W:0]   sum;

    // A load is never a wrap, so the strobe stays low on any load edge.
    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, incr_q};
        acc_d   = acc_q;
        incr_d  = incr_q;
        phase_d = phase_q;
        carry_d = 1'b0;
        if (load_cfg) begin
            incr_d  = cfg_incr;
            phase_d = cfg_phase;
            acc_d   = cfg_phase;
        end else if (load_sync) begin
            acc_d = phase_q;
        end else if (incr_q != '0) begin
            acc_d   = sum[ACC_W-1:0];
            carry_d = sum[ACC_W];
        end
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            incr_q  <= INIT_INCR;
            phase_q <= '0;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            incr_q  <= incr_d;
            phase_q <= phase_d;
            carry_q <= carry_d;
        end
    end

    assign carry_out = carry_q;
    assign msb_out   = acc_q[ACC_W-1] & (incr_q != '0);

endmodule

// File: rtl/multi_clk_div.sv
// Multi-channel DDS clock divider with a write/settle/lock handshake.
module multi_clk_div
    import multi_clk_div_pkg::*;
#(
    parameter int                      NUM_CH        = 4,
    parameter int                      ACC_W         = DEF_ACC_W,
    parameter int                      LOCK_CYCLES   = DEF_LOCK_CYCLES,
    parameter logic [NUM_CH*ACC_W-1:0] INIT_INCR     = '0,
    parameter bit                      GATE_UNLOCKED = 1'b1
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CHAN_W-1:0] cfg_chan,
    input  logic [ACC_W-1:0]  cfg_incr,
    input  logic [ACC_W-1:0]  cfg_phase,
    input  logic              cfg_sync,
    output logic [NUM_CH-1:0] en_out,
    output logic [NUM_CH-1:0] clk_out,
    output logic              locked
);

    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CHAN_W:0]   NUM_CH_L = (CHAN_W + 1)'(NUM_CH);

    state_t             state_q;
    logic [CNT_W-1:0]   settle_cnt_q;
    logic               locked_q;
    logic               cfg_accept;
    logic               out_gate;
    logic [NUM_CH-1:0]  carry;
    logic [NUM_CH-1:0]  msb;

    assign cfg_ready  = ~rst & (state_q != ST_APPLY);
    // Out-of-range channel writes complete the handshake but touch nothing.
    assign cfg_accept = cfg_valid & cfg_ready & ({1'b0, cfg_chan} < NUM_CH_L);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= '0;
            locked_q     <= 1'b0;
        end else if (cfg_accept) begin
            state_q      <= ST_APPLY;
            settle_cnt_q <= '0;
            locked_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_APPLY: begin
                    state_q      <= ST_SETTLE;
                    settle_cnt_q <= '0;
                end
                ST_SETTLE: begin
                    if (settle_cnt_q == LAST_CNT) begin
                        state_q  <= ST_LOCKED;
                        locked_q <= 1'b1;
                    end else begin
                        settle_cnt_q <= settle_cnt_q + 1'b1;
                    end
                end
                ST_LOCKED: begin
                    locked_q <= 1'b1;
                end
                default: begin
                    state_q      <= ST_SETTLE;
                    settle_cnt_q <= '0;
                    locked_q     <= 1'b0;
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            dds_channel #(
                .ACC_W     (ACC_W),
                .INIT_INCR (INIT_INCR[gi*ACC_W +: ACC_W])
            ) u_ch (
                .refclk    (refclk),
                .rst       (rst),
                .load_cfg  (cfg_accept && (cfg_chan == CHAN_W'(gi))),
                .load_sync (cfg_accept && cfg_sync),
                .cfg_incr  (cfg_incr),
                .cfg_phase (cfg_phase),
                .carry_out (carry[gi]),
                .msb_out   (msb[gi])
            );
        end
    endgenerate

    assign out_gate = GATE_UNLOCKED ? locked_q : 1'b1;
    assign en_out   = carry & {NUM_CH{out_gate}};
    assign clk_out  = msb & {NUM_CH{out_gate}};
    assign locked   = locked_q;

endmodule

// File: tb/tb_multi_clk_div.sv
// Scoreboard bench: a behavioural model pushes expected outputs per edge, checked after the edge.
module tb_multi_clk_div;

    localparam int NUM_CH      = 4;
    localparam int ACC_W       = 32;
    localparam int LOCK_CYCLES = 16;
    localparam logic [NUM_CH*ACC_W-1:0] INIT_INCR = {32'h0, 32'h0, 32'h0, 32'h4000_0000};

    typedef struct packed {
        logic [NUM_CH-1:0] en;
        logic [NUM_CH-1:0] clk;
        logic              lk;
        logic              rdy;
    } exp_t;

    logic              refclk;
    logic              rst;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [2:0]        cfg_chan;
    logic [ACC_W-1:0]  cfg_incr;
    logic [ACC_W-1:0]  cfg_phase;
    logic              cfg_sync;
    logic [NUM_CH-1:0] en_out;
    logic [NUM_CH-1:0] clk_out;
    logic              locked;

    int n_total = 0;
    int n_bad   = 0;

    exp_t sb_q[$];

    logic [ACC_W-1:0] m_acc [NUM_CH];
    logic [ACC_W-1:0] m_inc [NUM_CH];
    logic [ACC_W-1:0] m_ph  [NUM_CH];
    logic             m_cy  [NUM_CH];
    int m_edge, m_lock_at, m_acc_edge;

    multi_clk_div #(
        .NUM_CH        (NUM_CH),
        .ACC_W         (ACC_W),
        .LOCK_CYCLES   (LOCK_CYCLES),
        .INIT_INCR     (INIT_INCR),
        .GATE_UNLOCKED (1'b1)
    ) dut (
        .refclk    (refclk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_incr  (cfg_incr),
        .cfg_phase (cfg_phase),
        .cfg_sync  (cfg_sync),
        .en_out    (en_out),
        .clk_out   (clk_out),
        .locked    (locked)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Edges are counted from reset release; locked is due once m_edge reaches m_lock_at.
    task automatic m_reset();
        m_edge     = 0;
        m_lock_at  = LOCK_CYCLES;
        m_acc_edge = -100;
        for (int i = 0; i < NUM_CH; i++) begin
            m_acc[i] = '0;
            m_inc[i] = INIT_INCR[i*ACC_W +: ACC_W];
            m_ph[i]  = '0;
            m_cy[i]  = 1'b0;
        end
    endtask

    task automatic step(input logic v, input logic [2:0] ch, input logic [31:0] inc,
                        input logic [31:0] ph, input logic sy);
        exp_t e, got_e;
        logic [32:0] s;
        logic ok;
        cfg_valid = v;
        cfg_chan  = ch;
        cfg_incr  = inc;
        cfg_phase = ph;
        cfg_sync  = sy;
        ok = v && (m_acc_edge != m_edge) && (int'(ch) < NUM_CH);
        m_edge++;
        for (int i = 0; i < NUM_CH; i++) begin
            if (m_inc[i] != 0) begin
                s        = {1'b0, m_acc[i]} + {1'b0, m_inc[i]};
                m_acc[i] = s[31:0];
                m_cy[i]  = s[32];
            end else begin
                m_cy[i] = 1'b0;
            end
        end
        if (ok) begin
            if (sy) begin
                for (int i = 0; i < NUM_CH; i++) begin
                    m_acc[i] = m_ph[i];
                    m_cy[i]  = 1'b0;
                end
            end
            m_inc[ch]  = inc;
            m_ph[ch]   = ph;
            m_acc[ch]  = ph;
            m_cy[ch]   = 1'b0;
            m_lock_at  = m_edge + LOCK_CYCLES + 1;
            m_acc_edge = m_edge;
        end
        e.lk  = (m_edge >= m_lock_at);
        e.rdy = (m_acc_edge != m_edge);
        for (int i = 0; i < NUM_CH; i++) begin
            e.en[i]  = e.lk && m_cy[i];
            e.clk[i] = e.lk && (m_inc[i] != 0) && m_acc[i][31];
        end
        sb_q.push_back(e);
        if (v)
            $display("cfg write t=%0t ch=%0d incr=%h phase=%h sync=%0b taken=%0b",
                     $time, ch, inc, ph, sy, ok);
        @(posedge refclk);
        #1;
        got_e = sb_q.pop_front();
        check_eq($sformatf("en@%0d", m_edge), 32'(en_out), 32'(got_e.en));
        check_eq($sformatf("clk@%0d", m_edge), 32'(clk_out), 32'(got_e.clk));
        check_eq($sformatf("locked@%0d", m_edge), 32'(locked), 32'(got_e.lk));
        check_eq($sformatf("ready@%0d", m_edge), 32'(cfg_ready), 32'(got_e.rdy));
        cfg_valid = 1'b0;
        cfg_sync  = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 3'd0, 32'h0, 32'h0, 1'b0);
    endtask

    task automatic rst_cycle(input string tag);
        @(posedge refclk);
        #1;
        check_eq({tag, "_locked"}, 32'(locked), 32'h0);
        check_eq({tag, "_ready"}, 32'(cfg_ready), 32'h0);
        check_eq({tag, "_en"}, 32'(en_out), 32'h0);
        check_eq({tag, "_clk"}, 32'(clk_out), 32'h0);
    endtask

    // Raise rst between edges and look straight away: outputs must drop without a clock.
    task automatic pulse_rst(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_eq({tag, "_async_locked"}, 32'(locked), 32'h0);
        check_eq({tag, "_async_en"}, 32'(en_out), 32'h0);
        check_eq({tag, "_async_ready"}, 32'(cfg_ready), 32'h0);
        rst_cycle(tag);
        rst_cycle(tag);
        #2;
        rst = 1'b0;
        m_reset();
    endtask

    initial begin
        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_chan  = '0;
        cfg_incr  = '0;
        cfg_phase = '0;
        cfg_sync  = 1'b0;
        m_reset();
        for (int k = 0; k < 3; k++) rst_cycle("rst_hold");
        #2;
        rst = 1'b0;

        // Initial lock, ch0 divides by 4
        idle(24);

        // Write ch1 while locked; the held second request lands in APPLY and must be ignored
        step(1'b1, 3'd1, 32'h2000_0000, 32'h0, 1'b0);
        step(1'b1, 3'd2, 32'h0000_0005, 32'h8000_0000, 1'b0);
        idle(22);

        // Restart during SETTLE at count 5
        step(1'b1, 3'd1, 32'h2000_0000, 32'h1000_0000, 1'b0);
        idle(6);
        step(1'b1, 3'd2, 32'hC000_0000, 32'h1234_5678, 1'b0);
        idle(20);

        // Out-of-range channels while locked
        step(1'b1, 3'd7, 32'h1111_1111, 32'hFFFF_FFFF, 1'b1);
        idle(2);
        step(1'b1, 3'd5, 32'h2222_2222, 32'h0, 1'b0);
        idle(4);

        // Sync write: ch1 aligns to ch0's stored phase 0
        step(1'b1, 3'd1, 32'h4000_0000, 32'h0, 1'b1);
        idle(24);

        // Reset while locked, then reset during SETTLE, then full relock
        step(1'b1, 3'd3, 32'h0800_0000, 32'h7000_0000, 1'b0);
        idle(20);
        pulse_rst("rst_locked");
        idle(8);
        pulse_rst("rst_settle");
        idle(20);

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0)
                step(1'b1, 3'($urandom_range(0, 7)),
                     ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom),
                     32'($urandom), ($urandom_range(0, 3) == 0));
            else
                idle(1);
        end
        idle(20);

        check_eq("sb_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
